// File: rtl/bc_sched_pkg.sv
// Shared encodings and helpers for the bus-connect scheduler.
package bc_sched_pkg;

    localparam int BC_ADDR_W = 4;

    // DRR source select codes
    localparam logic [1:0] DRR_DG   = 2'b00;
    localparam logic [1:0] DRR_PS   = 2'b01;
    localparam logic [1:0] DRR_XB   = 2'b10;
    localparam logic [1:0] DRR_NONE = 2'b11;

    // DI source select codes (bit 2 is reserved and always zero)
    localparam logic [2:0] DI_DM   = 3'b000;
    localparam logic [2:0] DI_PDR  = 3'b001;
    localparam logic [2:0] DI_IMM  = 3'b010;
    localparam logic [2:0] DI_NONE = 3'b011;

    // Round-robin pointer positions
    typedef enum logic [1:0] {
        RR_DG = 2'd0,
        RR_PS = 2'd1,
        RR_XB = 2'd2
    } rr_src_e;

    // Next position in the DG -> PS -> XB -> DG rotation
    function automatic logic [1:0] rr_next(input logic [1:0] p);
        logic [1:0] n;
        case (p)
            2'd0:    n = 2'd1;
            2'd1:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bc_rr_arb3.sv
// Three-way round-robin arbiter: search starts at i_ptr, one-hot grant out.
module bc_rr_arb3
    import bc_sched_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic [1:0] i_ptr,
    input  logic       i_en,
    output logic [2:0] o_gnt,
    output logic [1:0] o_nxt_ptr
);

    // Request bit at a rotation position (invalid positions never request)
    function automatic logic req_at(input logic [2:0] r, input logic [1:0] p);
        logic v;
        case (p)
            2'd0:    v = r[0];
            2'd1:    v = r[1];
            2'd2:    v = r[2];
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    // One-hot vector for a rotation position
    function automatic logic [2:0] onehot(input logic [1:0] p);
        logic [2:0] v;
        case (p)
            2'd0:    v = 3'b001;
            2'd1:    v = 3'b010;
            2'd2:    v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    logic [1:0] w_idx;
    logic       w_found;

    // Walk the rotation from the pointer and grant the first requester
    always_comb begin
        o_gnt     = 3'b000;
        o_nxt_ptr = i_ptr;
        w_found   = 1'b0;
        w_idx     = i_ptr;
        for (int k = 0; k < 3; k++) begin
            if (i_en && !w_found && req_at(i_req, w_idx)) begin
                o_gnt     = onehot(w_idx);
                o_nxt_ptr = rr_next(w_idx);
                w_found   = 1'b1;
            end else begin
                w_found   = w_found;
            end
            w_idx = rr_next(w_idx);
        end
    end

endmodule

// File: rtl/bc_sched.sv
// Bus-connect scheduler: round-robin DRR path with a one-cycle pipeline
// slot, plus a DI path shared by DM loads, immediates and the DRR slot.
module bc_sched
    import bc_sched_pkg::*;
#(
    parameter int ADDR_W     = BC_ADDR_W,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk_dcd,
    input  logic              reset,
    input  logic              dg_bc_req,
    input  logic [ADDR_W-1:0] dg_bc_wa,
    input  logic              ps_bc_req,
    input  logic [ADDR_W-1:0] ps_bc_wa,
    input  logic              xb_bc_req,
    input  logic [ADDR_W-1:0] xb_bc_wa,
    input  logic              dm_bc_req,
    input  logic [ADDR_W-1:0] dm_bc_wa,
    input  logic              ps_bc_imm_req,
    input  logic [ADDR_W-1:0] ps_bc_imm_wa,
    output logic              bc_dg_gnt,
    output logic              bc_ps_gnt,
    output logic              bc_xb_gnt,
    output logic              bc_dm_gnt,
    output logic              bc_imm_gnt,
    output logic [1:0]        ps_bc_drr_sclt,
    output logic [2:0]        ps_bc_di_sclt,
    output logic              bc_rf_we,
    output logic [ADDR_W-1:0] bc_rf_wa,
    output logic              bc_busy
);

    localparam int SW = $clog2(STARVE_MAX) + 1;

    logic              r_s2_vld;
    logic [ADDR_W-1:0] r_s2_wa;
    logic [1:0]        r_rr_ptr;
    logic [SW-1:0]     r_starve_cnt;
    logic              r_di_wait;

    logic [2:0]        w_drr_gnt;
    logic [1:0]        w_nxt_ptr;
    logic              w_drr_en;
    logic [ADDR_W-1:0] w_drr_wa;
    logic              w_dm_gnt;
    logic              w_imm_gnt;
    logic              w_di_denied;

    // Holding DRR off after a DI denial keeps the next DI slot free of the pipeline
    assign w_drr_en = !reset && !(r_di_wait && (dm_bc_req || ps_bc_imm_req));

    bc_rr_arb3 u_arb (
        .i_req     ({xb_bc_req, ps_bc_req, dg_bc_req}),
        .i_ptr     (r_rr_ptr),
        .i_en      (w_drr_en),
        .o_gnt     (w_drr_gnt),
        .o_nxt_ptr (w_nxt_ptr)
    );

    assign bc_dg_gnt  = w_drr_gnt[0];
    assign bc_ps_gnt  = w_drr_gnt[1];
    assign bc_xb_gnt  = w_drr_gnt[2];
    assign bc_dm_gnt  = w_dm_gnt;
    assign bc_imm_gnt = w_imm_gnt;
    assign bc_busy    = reset ? 1'b0 : r_s2_vld;

    assign w_di_denied = (dm_bc_req && !w_dm_gnt) || (ps_bc_imm_req && !w_imm_gnt);

    // DRR select code and destination address of the granted source
    always_comb begin
        ps_bc_drr_sclt = DRR_NONE;
        w_drr_wa       = {ADDR_W{1'b0}};
        case (w_drr_gnt)
            3'b001: begin ps_bc_drr_sclt = DRR_DG; w_drr_wa = dg_bc_wa; end
            3'b010: begin ps_bc_drr_sclt = DRR_PS; w_drr_wa = ps_bc_wa; end
            3'b100: begin ps_bc_drr_sclt = DRR_XB; w_drr_wa = xb_bc_wa; end
            default: begin ps_bc_drr_sclt = DRR_NONE; w_drr_wa = {ADDR_W{1'b0}}; end
        endcase
    end

    // DI path: pipelined slot first, then DM over IMM unless IMM is starving
    always_comb begin
        ps_bc_di_sclt = DI_NONE;
        bc_rf_we      = 1'b0;
        bc_rf_wa      = {ADDR_W{1'b0}};
        w_dm_gnt      = 1'b0;
        w_imm_gnt     = 1'b0;
        if (reset) begin
            ps_bc_di_sclt = DI_NONE;
        end else if (r_s2_vld) begin
            ps_bc_di_sclt = DI_PDR;
            bc_rf_we      = 1'b1;
            bc_rf_wa      = r_s2_wa;
        end else if (dm_bc_req && (!ps_bc_imm_req || (r_starve_cnt < SW'(STARVE_MAX)))) begin
            ps_bc_di_sclt = DI_DM;
            bc_rf_we      = 1'b1;
            bc_rf_wa      = dm_bc_wa;
            w_dm_gnt      = 1'b1;
        end else if (ps_bc_imm_req) begin
            ps_bc_di_sclt = DI_IMM;
            bc_rf_we      = 1'b1;
            bc_rf_wa      = ps_bc_imm_wa;
            w_imm_gnt     = 1'b1;
        end else begin
            ps_bc_di_sclt = DI_NONE;
        end
    end

    // Stage-2 slot, rotation pointer, starvation counter and DI-denied flag
    always_ff @(posedge clk_dcd) begin
        if (reset) begin
            r_s2_vld     <= 1'b0;
            r_s2_wa      <= {ADDR_W{1'b0}};
            r_rr_ptr     <= RR_DG;
            r_starve_cnt <= {SW{1'b0}};
            r_di_wait    <= 1'b0;
        end else begin
            r_s2_vld  <= |w_drr_gnt;
            r_di_wait <= w_di_denied;
            if (|w_drr_gnt) begin
                r_s2_wa  <= w_drr_wa;
                r_rr_ptr <= w_nxt_ptr;
            end else begin
                r_s2_wa  <= r_s2_wa;
                r_rr_ptr <= r_rr_ptr;
            end
            if (ps_bc_imm_req && !w_imm_gnt) begin
                if (r_starve_cnt >= SW'(STARVE_MAX)) begin
                    r_starve_cnt <= r_starve_cnt;
                end else begin
                    r_starve_cnt <= r_starve_cnt + SW'(1);
                end
            end else begin
                r_starve_cnt <= {SW{1'b0}};
            end
        end
    end

endmodule
